// File: rtl/cnt_bus_pkg.sv
// Shared definitions for the counter-bus scheduler.
//   N_POLL     : number of counter read registers covered by one poll scan
//   POLL_ADDR  : register-bus address of each poll index, index 0 in the low byte
//   state_e    : scheduler FSM states
//   ST_IDLE/ST_ACC : the same states as plain constants for logic-typed state regs
package cnt_bus_pkg;

    localparam int N_POLL = 6;

    localparam logic [N_POLL-1:0][7:0] POLL_ADDR = {
        8'h23, 8'h22, 8'h21, 8'h20, 8'h11, 8'h10
    };

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACC  = 1'b1;

endpackage

// File: rtl/cnt_bus_sched_if.sv
// Single-master register bus between the scheduler and the counter register file.
//   cs, rw, addr, wdata : strobe, direction (1 = write), address, write data
//   rdata               : read data, combinational in the same cycle as cs
// master modport is the scheduler side, slave modport the register-file side.
interface cnt_bus_sched_if;
    logic        cs;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs, rw, addr, wdata, input rdata);
    modport slave  (input cs, rw, addr, wdata, output rdata);
endinterface

// File: rtl/cnt_poll_timer.sv
// Poll-scan tick generator: a down-counter that reloads POLL_PERIOD-1.
//   clk, rst : clock and synchronous active-high reset
//   poll_en  : run enable; when low the counter is held at the reload value
//   tick     : high for one cycle every POLL_PERIOD enabled cycles
module cnt_poll_timer #(
    parameter int POLL_PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic poll_en,
    output logic tick
);

    localparam int             TW     = $clog2(POLL_PERIOD);
    localparam logic [TW-1:0]  RELOAD = TW'(POLL_PERIOD - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !poll_en || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - TW'(1);
        end
    end

    assign tick = poll_en && (cnt == '0);

endmodule

// File: rtl/cnt_bus_sched.sv
// Arbiter/sequencer owning the counter register bus. Shares it between a host
// command port and a periodic poll engine that snapshots the six counter read
// registers into a coherent visible buffer.
//   clk, rst              : clock, synchronous active-high reset
//   h_req/h_rw/h_addr/h_wdata : host request (level, held until h_ack)
//   h_ack/h_rdata         : host completion pulse and read data
//   poll_en               : poll timer enable
//   snap_sel/snap_data    : combinational read of the visible snapshot
//   snap_done             : pulse when a scan commits to the visible buffer
//   snap_ovr/snap_ovr_clr : sticky dropped-tick flag and its clear
//   bus                   : register bus master port
//
// state | meaning
// IDLE  | arbitrate between host and poll, cs low
// ACC   | one-cycle bus access, capture rdata
module cnt_bus_sched
    import cnt_bus_pkg::*;
#(
    parameter int POLL_PERIOD  = 1000,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_req,
    input  logic        h_rw,
    input  logic [7:0]  h_addr,
    input  logic [31:0] h_wdata,
    output logic        h_ack,
    output logic [31:0] h_rdata,
    input  logic        poll_en,
    input  logic [2:0]  snap_sel,
    output logic [31:0] snap_data,
    output logic        snap_done,
    output logic        snap_ovr,
    input  logic        snap_ovr_clr,
    cnt_bus_sched_if.master bus
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [2:0]    LAST_IDX   = 3'(N_POLL - 1);

    logic [0:0]  state;
    logic        cs_q;
    logic        rw_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic        h_ack_q;
    logic [31:0] h_rdata_q;
    logic        snap_done_q;
    logic        snap_ovr_q;
    logic        scan_act;
    logic [2:0]  poll_idx;
    logic        gnt_poll;
    logic [SW-1:0] streak;
    logic [31:0] shadow  [N_POLL];
    logic [31:0] visible [N_POLL];

    logic tick;
    logic host_cand;
    logic poll_win;
    logic host_win;

    cnt_poll_timer #(
        .POLL_PERIOD(POLL_PERIOD)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .poll_en(poll_en),
        .tick   (tick)
    );

    // A held h_req stays masked during its own ack cycle. Poll only takes that
    // slot when the host has really let go of h_req (or is starving the scan),
    // so a continuously requesting host sees STARVE_LIMIT grants per poll.
    assign host_cand = h_req && !h_ack_q;
    assign poll_win  = scan_act && ((streak == STREAK_MAX) || !h_req);
    assign host_win  = host_cand && !poll_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cs_q        <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            h_ack_q     <= 1'b0;
            h_rdata_q   <= '0;
            snap_done_q <= 1'b0;
            snap_ovr_q  <= 1'b0;
            scan_act    <= 1'b0;
            poll_idx    <= '0;
            gnt_poll    <= 1'b0;
            streak      <= '0;
            for (int i = 0; i < N_POLL; i++) begin
                shadow[i]  <= '0;
                visible[i] <= '0;
            end
        end else begin
            h_ack_q     <= 1'b0;
            snap_done_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (poll_win) begin
                        state    <= ST_ACC;
                        cs_q     <= 1'b1;
                        rw_q     <= 1'b0;
                        addr_q   <= POLL_ADDR[poll_idx];
                        wdata_q  <= '0;
                        gnt_poll <= 1'b1;
                    end else if (host_win) begin
                        state    <= ST_ACC;
                        cs_q     <= 1'b1;
                        rw_q     <= h_rw;
                        addr_q   <= h_addr;
                        wdata_q  <= h_wdata;
                        gnt_poll <= 1'b0;
                    end
                end
                ST_ACC: begin
                    state <= ST_IDLE;
                    cs_q  <= 1'b0;
                    if (gnt_poll) begin
                        shadow[poll_idx] <= bus.rdata;
                        if (poll_idx == LAST_IDX) begin
                            // Commit straight from rdata for the final word so
                            // visible and snap_done change on the same edge.
                            for (int i = 0; i < N_POLL; i++) begin
                                visible[i] <= (3'(i) == poll_idx) ? bus.rdata : shadow[i];
                            end
                            snap_done_q <= 1'b1;
                            scan_act    <= 1'b0;
                        end else begin
                            poll_idx <= poll_idx + 3'd1;
                        end
                    end else begin
                        h_ack_q <= 1'b1;
                        if (!rw_q) begin
                            h_rdata_q <= bus.rdata;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cs_q  <= 1'b0;
                end
            endcase

            if (!scan_act) begin
                streak <= '0;
            end else if (state == ST_IDLE && poll_win) begin
                streak <= '0;
            end else if (state == ST_IDLE && host_win && streak != STREAK_MAX) begin
                streak <= streak + SW'(1);
            end

            // Scan start only happens with scan_act low and commit only with it
            // high, so the two never collide on scan_act/poll_idx.
            if (tick && !scan_act) begin
                scan_act <= 1'b1;
                poll_idx <= '0;
            end

            if (tick && scan_act) begin
                snap_ovr_q <= 1'b1;
            end else if (snap_ovr_clr) begin
                snap_ovr_q <= 1'b0;
            end
        end
    end

    always_comb begin
        snap_data = '0;
        if (snap_sel < 3'(N_POLL)) begin
            snap_data = visible[snap_sel];
        end
    end

    assign bus.cs    = cs_q;
    assign bus.rw    = rw_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign h_ack     = h_ack_q;
    assign h_rdata   = h_rdata_q;
    assign snap_done = snap_done_q;
    assign snap_ovr  = snap_ovr_q;

endmodule

// File: tb/tb_cnt_bus_sched.sv
// Directed bench for cnt_bus_sched with a small combinational register-file model.
module tb_cnt_bus_sched;

    localparam int PP = 16;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        h_req;
    logic        h_rw;
    logic [7:0]  h_addr;
    logic [31:0] h_wdata;
    logic        h_ack;
    logic [31:0] h_rdata;
    logic        poll_en;
    logic [2:0]  snap_sel;
    logic [31:0] snap_data;
    logic        snap_done;
    logic        snap_ovr;
    logic        snap_ovr_clr;

    cnt_bus_sched_if bus ();

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_model(input logic [7:0] a);
        case (a)
            8'h10:   return 32'h0A0B0C0D;
            8'h11:   return 32'h11111111;
            8'h20:   return 32'h12345678;
            8'h21:   return 32'h21212121;
            8'h22:   return 32'h22222222;
            8'h23:   return 32'h23232323;
            8'h40:   return 32'hCAFE0040;
            default: return 32'h0;
        endcase
    endfunction

    assign bus.rdata = bus.cs ? reg_model(bus.addr) : 32'h0;

    cnt_bus_sched #(
        .POLL_PERIOD (PP),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .h_req       (h_req),
        .h_rw        (h_rw),
        .h_addr      (h_addr),
        .h_wdata     (h_wdata),
        .h_ack       (h_ack),
        .h_rdata     (h_rdata),
        .poll_en     (poll_en),
        .snap_sel    (snap_sel),
        .snap_data   (snap_data),
        .snap_done   (snap_done),
        .snap_ovr    (snap_ovr),
        .snap_ovr_clr(snap_ovr_clr),
        .bus         (bus.master)
    );

    logic [7:0] pa [6] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23};

    int checks   = 0;
    int failures = 0;

    int first_cs, last_cs, done_at, n_cs, n_rw1, n_host, n_poll, n_ack, n_done, gap;
    logic [7:0] seen [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_snap(input bit zero);
        for (int s = 0; s < 8; s++) begin
            snap_sel = 3'(s);
            #1;
            if (s < 6 && !zero) chk($sformatf("snap_data[%0d]", s), snap_data, reg_model(pa[s]));
            else                chk($sformatf("snap_data[%0d]", s), snap_data, 32'h0);
        end
        snap_sel = 3'd0;
    endtask

    initial begin
        rst = 1'b1; h_req = 1'b0; h_rw = 1'b0; h_addr = 8'h0; h_wdata = 32'h0;
        poll_en = 1'b0; snap_sel = 3'd0; snap_ovr_clr = 1'b0;
        step(); step();

        chk("rst_cs", {31'h0, bus.cs}, 32'h0);
        chk("rst_rw", {31'h0, bus.rw}, 32'h0);
        chk("rst_addr", {24'h0, bus.addr}, 32'h0);
        chk("rst_wdata", bus.wdata, 32'h0);
        chk("rst_h_ack", {31'h0, h_ack}, 32'h0);
        chk("rst_h_rdata", h_rdata, 32'h0);
        chk("rst_snap_done", {31'h0, snap_done}, 32'h0);
        chk("rst_snap_ovr", {31'h0, snap_ovr}, 32'h0);
        check_snap(1'b1);
        rst = 1'b0;
        step();

        // host read 0x20
        h_rw = 1'b0; h_addr = 8'h20; h_req = 1'b1;
        step();
        chk("rd_cs_t1", {31'h0, bus.cs}, 32'h1);
        chk("rd_rw", {31'h0, bus.rw}, 32'h0);
        chk("rd_addr", {24'h0, bus.addr}, 32'h20);
        chk("rd_ack_t1", {31'h0, h_ack}, 32'h0);
        step();
        chk("rd_ack_t2", {31'h0, h_ack}, 32'h1);
        chk("rd_cs_t2", {31'h0, bus.cs}, 32'h0);
        chk("rd_rdata", h_rdata, 32'h12345678);
        h_req = 1'b0;
        step();
        chk("rd_ack_drop", {31'h0, h_ack}, 32'h0);

        // host write 0x03
        h_rw = 1'b1; h_addr = 8'h03; h_wdata = 32'hAABBCCDD; h_req = 1'b1;
        step();
        chk("wr_cs", {31'h0, bus.cs}, 32'h1);
        chk("wr_rw", {31'h0, bus.rw}, 32'h1);
        chk("wr_addr", {24'h0, bus.addr}, 32'h03);
        chk("wr_wdata", bus.wdata, 32'hAABBCCDD);
        step();
        chk("wr_ack", {31'h0, h_ack}, 32'h1);
        chk("wr_cs_off", {31'h0, bus.cs}, 32'h0);
        chk("wr_rdata_kept", h_rdata, 32'h12345678);
        h_req = 1'b0; h_rw = 1'b0;
        step();
        chk("wr_ack_drop", {31'h0, h_ack}, 32'h0);

        // poll-only scan
        first_cs = -1; last_cs = -1; done_at = -1; n_cs = 0; n_rw1 = 0;
        poll_en = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (bus.cs) begin
                if (n_cs < 6) seen[n_cs] = bus.addr;
                if (first_cs < 0) first_cs = i;
                last_cs = i;
                if (bus.rw) n_rw1++;
                n_cs++;
            end
            if (snap_done) begin
                done_at = i;
                poll_en = 1'b0;
                break;
            end
        end
        chk("poll_first_cs", 32'(first_cs), 32'd17);
        chk("poll_n_acc", 32'(n_cs), 32'd6);
        chk("poll_rw_writes", 32'(n_rw1), 32'd0);
        chk("poll_last_cs", 32'(last_cs), 32'(first_cs + 10));
        chk("poll_done_at", 32'(done_at), 32'(last_cs + 1));
        for (int k = 0; k < 6; k++) chk($sformatf("poll_addr[%0d]", k), {24'h0, seen[k]}, {24'h0, pa[k]});
        step();
        chk("poll_done_pulse", {31'h0, snap_done}, 32'h0);
        chk("poll_no_ovr", {31'h0, snap_ovr}, 32'h0);
        check_snap(1'b0);

        // continuous host traffic during a scan
        h_rw = 1'b0; h_addr = 8'h40; h_req = 1'b1; poll_en = 1'b1;
        n_host = 0; n_poll = 0; n_ack = 0; n_done = 0; gap = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (h_ack) n_ack++;
            if (bus.cs) begin
                if (bus.addr == 8'h40) begin
                    n_host++;
                    if (i > 16) gap++;
                end else begin
                    chk($sformatf("starve_gap[%0d]", n_poll), 32'(gap), 32'(SL));
                    gap = 0;
                    n_poll++;
                end
            end
            if (snap_done) begin
                n_done++;
                h_req = 1'b0;
                poll_en = 1'b0;
                break;
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (h_ack) n_ack++;
            if (snap_done) n_done++;
        end
        chk("starve_n_poll", 32'(n_poll), 32'd6);
        chk("starve_n_done", 32'(n_done), 32'd1);
        chk("starve_acks", 32'(n_ack), 32'(n_host));
        chk("starve_h_rdata", h_rdata, 32'hCAFE0040);
        chk("ovr_set", {31'h0, snap_ovr}, 32'h1);
        check_snap(1'b0);

        snap_ovr_clr = 1'b1;
        step();
        chk("ovr_clr", {31'h0, snap_ovr}, 32'h0);
        snap_ovr_clr = 1'b0;

        // tick lands mid-scan together with a clear
        h_req = 1'b1; poll_en = 1'b1;
        for (int i = 0; i < 31; i++) step();
        chk("ovr_before", {31'h0, snap_ovr}, 32'h0);
        snap_ovr_clr = 1'b1;
        step();
        chk("ovr_set_beats_clr", {31'h0, snap_ovr}, 32'h1);
        step();
        chk("ovr_clr_after", {31'h0, snap_ovr}, 32'h0);
        snap_ovr_clr = 1'b0;

        rst = 1'b1; h_req = 1'b0; poll_en = 1'b0;
        step();
        rst = 1'b0;
        step();

        // reset after the third poll access
        poll_en = 1'b1; n_cs = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.cs) n_cs++;
            if (n_cs == 3) break;
        end
        chk("abort_3rd_acc", 32'(n_cs), 32'd3);
        chk("abort_3rd_addr", {24'h0, bus.addr}, 32'h20);
        step();
        rst = 1'b1;
        step();
        chk("abort_cs", {31'h0, bus.cs}, 32'h0);
        chk("abort_rw", {31'h0, bus.rw}, 32'h0);
        chk("abort_addr", {24'h0, bus.addr}, 32'h0);
        chk("abort_wdata", bus.wdata, 32'h0);
        chk("abort_h_ack", {31'h0, h_ack}, 32'h0);
        chk("abort_h_rdata", h_rdata, 32'h0);
        chk("abort_snap_done", {31'h0, snap_done}, 32'h0);
        chk("abort_snap_ovr", {31'h0, snap_ovr}, 32'h0);
        check_snap(1'b1);
        rst = 1'b0;

        first_cs = -1; done_at = -1; n_done = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (bus.cs && first_cs < 0) first_cs = i;
            if (snap_done) begin
                n_done++;
                if (done_at < 0) done_at = i;
                poll_en = 1'b0;
                break;
            end
        end
        chk("restart_first_cs", 32'(first_cs), 32'd17);
        chk("restart_done_at", 32'(done_at), 32'd28);
        chk("restart_n_done", 32'(n_done), 32'd1);
        check_snap(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
